// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared pipeline constants and the hazard unit's forwarding helper.
//   pipeline_pkg                : register-index width, forwarding-select
//                                 encodings, PC-source redirect encodings.
//   scoreboard_hazard_unit_pkg  : fwd_pick() operand forwarding decision.
package pipeline_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [1:0] FWD_RF = 2'b00;   // operand from register file
   localparam logic [1:0] FWD_XM = 2'b01;   // operand from X/M pipeline register
   localparam logic [1:0] FWD_MW = 2'b10;   // operand from M/W pipeline register

   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_BR   = 2'b01;
   localparam logic [1:0] PC_JMP  = 2'b10;
   localparam logic [1:0] PC_RSVD = 2'b11;

   function automatic logic is_redirect(input logic [1:0] pc_src);
      return (pc_src == PC_BR) || (pc_src == PC_JMP);
   endfunction

endpackage

package scoreboard_hazard_unit_pkg;

   import pipeline_pkg::*;

   // X/M has priority over M/W because it holds the younger result.
   function automatic logic [1:0] fwd_pick(input logic [REG_IDX_W-1:0] src,
                                           input logic [REG_IDX_W-1:0] x_dst,
                                           input logic                 x_we,
                                           input logic [REG_IDX_W-1:0] m_dst,
                                           input logic                 m_we);
      if (src != '0 && x_we && src == x_dst) return FWD_XM;
      if (src != '0 && m_we && src == m_dst) return FWD_MW;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Bundle of Decode/Execute/Memory status inputs and hazard-control outputs.
//   master : pipeline side (drives decode/execute status, receives controls)
//   slave  : hazard unit side
interface scoreboard_hazard_unit_if
   import pipeline_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int LAT_W    = 3
);
   logic                          d_valid;
   logic [NUM_SRC*REG_IDX_W-1:0]  d_src_reg;
   logic [NUM_SRC-1:0]            d_src_used;
   logic [REG_IDX_W-1:0]          d_dst_reg;
   logic                          d_reg_write;
   logic [LAT_W-1:0]              d_latency;
   logic [REG_IDX_W-1:0]          x_dst_reg;
   logic [REG_IDX_W-1:0]          m_dst_reg;
   logic                          x_reg_write;
   logic                          m_reg_write;
   logic                          x_valid;
   logic                          x_alu_ready;
   logic [1:0]                    pc_src;

   logic                          f_stall;
   logic                          d_stall;
   logic                          x_stall;
   logic                          f_flush;
   logic                          d_flush;
   logic                          x_bubble;
   logic [NUM_SRC*2-1:0]          x_fwd_sel;
   logic [NUM_REGS-1:0]           busy_vec;
   logic [31:0]                   stall_count;
   logic [31:0]                   flush_count;

   modport master (
      output d_valid, d_src_reg, d_src_used, d_dst_reg, d_reg_write, d_latency,
             x_dst_reg, m_dst_reg, x_reg_write, m_reg_write, x_valid, x_alu_ready,
             pc_src,
      input  f_stall, d_stall, x_stall, f_flush, d_flush, x_bubble, x_fwd_sel,
             busy_vec, stall_count, flush_count
   );

   modport slave (
      input  d_valid, d_src_reg, d_src_used, d_dst_reg, d_reg_write, d_latency,
             x_dst_reg, m_dst_reg, x_reg_write, m_reg_write, x_valid, x_alu_ready,
             pc_src,
      output f_stall, d_stall, x_stall, f_flush, d_flush, x_bubble, x_fwd_sel,
             busy_vec, stall_count, flush_count
   );

endinterface

// File: rtl/scoreboard_hazard_unit_reg_scoreboard.sv
// reg_scoreboard: one LAT_W-bit countdown per architectural register.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   i_freeze      : hold every counter (Execute stalled)
//   i_load        : load i_load_val into counter i_load_idx (overrides decrement)
//   o_cnt         : all counters, register r at [r*LAT_W +: LAT_W]
//   o_busy_vec    : bit r set while counter r is nonzero
// Register 0 is hardwired to zero and never tracked.
module reg_scoreboard
   import pipeline_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int LAT_W    = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_freeze,
   input  logic                      i_load,
   input  logic [REG_IDX_W-1:0]      i_load_idx,
   input  logic [LAT_W-1:0]          i_load_val,
   output logic [NUM_REGS*LAT_W-1:0] o_cnt,
   output logic [NUM_REGS-1:0]       o_busy_vec
);

   logic [LAT_W-1:0] r_cnt [NUM_REGS];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      end else if (!i_freeze) begin
         r_cnt[0] <= '0;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (i_load && i_load_idx == REG_IDX_W'(r))
               r_cnt[r] <= i_load_val;
            else if (r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - LAT_W'(1);
         end
      end
   end

   always_comb begin
      o_cnt      = '0;
      o_busy_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         o_cnt[r*LAT_W +: LAT_W] = r_cnt[r];
         o_busy_vec[r]           = (r_cnt[r] != '0);
      end
   end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: scoreboard-based RAW/WAW stall, flush, bubble and
// operand-forwarding control for an in-order pipeline.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   hz (slave)   : decode/execute/memory status in, stall/flush/bubble,
//                  registered x_fwd_sel, busy_vec and perf counters out
// Optional: define HAZARD_PERF_EN to enable stall_count / flush_count;
// otherwise both read as zero.
module scoreboard_hazard_unit
   import pipeline_pkg::*;
   import scoreboard_hazard_unit_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int LAT_W    = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   scoreboard_hazard_unit_if.slave hz
);

   logic [NUM_REGS*LAT_W-1:0] w_cnt_flat;
   logic [LAT_W-1:0]          w_lat_eff;
   logic [LAT_W-1:0]          w_dst_cnt;
   logic                      w_raw;
   logic                      w_waw;
   logic                      w_flush;
   logic                      w_x_stall;
   logic                      w_d_stall;
   logic                      w_issue;
   logic                      w_load;
   logic [NUM_SRC*2-1:0]      w_fwd_next;
   logic [NUM_SRC*2-1:0]      r_fwd_sel;

   assign w_lat_eff = (hz.d_latency == '0) ? LAT_W'(1) : hz.d_latency;
   assign w_dst_cnt = w_cnt_flat[int'(hz.d_dst_reg)*LAT_W +: LAT_W];

   // Hazards are judged on the count that remains after this edge: a count of
   // 1 means the producer lands in X/M at this edge and is forwardable, so a
   // reader only stalls while more than one cycle remains, and a writer only
   // stalls if the older write would still land at or after its own.
   always_comb begin
      logic [REG_IDX_W-1:0] src;
      w_raw      = 1'b0;
      w_fwd_next = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src = hz.d_src_reg[REG_IDX_W*i +: REG_IDX_W];
         if (hz.d_src_used[i] && src != '0 &&
             w_cnt_flat[int'(src)*LAT_W +: LAT_W] > LAT_W'(1))
            w_raw = 1'b1;
         w_fwd_next[2*i +: 2] = fwd_pick(src, hz.x_dst_reg, hz.x_reg_write,
                                         hz.m_dst_reg, hz.m_reg_write);
      end
   end

   assign w_waw     = hz.d_reg_write && hz.d_dst_reg != '0 && w_dst_cnt > w_lat_eff;
   assign w_flush   = is_redirect(hz.pc_src);
   assign w_x_stall = hz.x_valid & ~hz.x_alu_ready;
   // Flush dominates a decode hazard; an Execute stall still holds decode.
   assign w_d_stall = w_x_stall | (hz.d_valid & (w_raw | w_waw) & ~w_flush);
   assign w_issue   = hz.d_valid & ~w_d_stall & ~w_flush;
   assign w_load    = w_issue & hz.d_reg_write & (hz.d_dst_reg != '0);

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .LAT_W    (LAT_W)
   ) u_sb (
      .clock      (clock),
      .reset      (reset),
      .i_freeze   (w_x_stall),
      .i_load     (w_load),
      .i_load_idx (hz.d_dst_reg),
      .i_load_val (w_lat_eff),
      .o_cnt      (w_cnt_flat),
      .o_busy_vec (hz.busy_vec)
   );

   // Execute selects track what enters Execute: hold while it is stalled,
   // clear when a bubble (or nothing) enters.
   always_ff @(posedge clock) begin
      if (reset)
         r_fwd_sel <= '0;
      else if (w_x_stall)
         r_fwd_sel <= r_fwd_sel;
      else if (w_issue)
         r_fwd_sel <= w_fwd_next;
      else
         r_fwd_sel <= '0;
   end

   assign hz.x_fwd_sel = r_fwd_sel;
   assign hz.f_stall   = w_d_stall;
   assign hz.d_stall   = w_d_stall;
   assign hz.x_stall   = w_x_stall;
   assign hz.f_flush   = w_flush;
   assign hz.d_flush   = w_flush;
   assign hz.x_bubble  = (w_d_stall & ~w_x_stall) | w_flush;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_count;
   logic [31:0] r_flush_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_d_stall) r_stall_count <= r_stall_count + 32'd1;
         if (w_flush)   r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign hz.stall_count = r_stall_count;
   assign hz.flush_count = r_flush_count;
`else
   assign hz.stall_count = '0;
   assign hz.flush_count = '0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed latency scenarios followed by
// randomized traffic, all checked against a timestamp-based reference model
// (each register remembers the cycle its result becomes forwardable).
module tb_scoreboard_hazard_unit;
   import pipeline_pkg::*;

   localparam int NR = 32;
   localparam int NS = 2;
   localparam int LW = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   scoreboard_hazard_unit_if #(.NUM_REGS(NR), .NUM_SRC(NS), .LAT_W(LW)) hz ();

   scoreboard_hazard_unit #(.NUM_REGS(NR), .NUM_SRC(NS), .LAT_W(LW)) dut (
      .clock (clock),
      .reset (reset),
      .hz    (hz)
   );

   // Model: ready[r] is the active-cycle time at which r's pending count
   // reaches zero; t_act advances only on cycles where Execute is not stalled.
   int          ready [NR];
   int          t_act;
   logic [2*NS-1:0] exp_fwd;
   logic [31:0] exp_scnt;
   logic [31:0] exp_fcnt;
   logic        obs_dstall;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_idle();
      reset          = 1'b0;
      hz.d_valid     = 1'b0;
      hz.d_src_reg   = '0;
      hz.d_src_used  = '0;
      hz.d_dst_reg   = '0;
      hz.d_reg_write = 1'b0;
      hz.d_latency   = LW'(1);
      hz.x_dst_reg   = '0;
      hz.m_dst_reg   = '0;
      hz.x_reg_write = 1'b0;
      hz.m_reg_write = 1'b0;
      hz.x_valid     = 1'b0;
      hz.x_alu_ready = 1'b1;
      hz.pc_src      = PC_SEQ;
   endtask

   // Inputs are set at the negedge; check 2 ns later, advance the model for
   // the coming posedge, then return at the following negedge.
   task automatic cycle();
      logic fl, xs, haz, ds, iss, bub;
      logic [LW-1:0] lat;
      logic [NR-1:0] busy_e;
      logic [4:0] s;
      logic [1:0] f;
      #2;
      fl  = (hz.pc_src == 2'b01) || (hz.pc_src == 2'b10);
      xs  = hz.x_valid && !hz.x_alu_ready;
      lat = (hz.d_latency == '0) ? LW'(1) : hz.d_latency;
      haz = 1'b0;
      for (int i = 0; i < NS; i++) begin
         s = hz.d_src_reg[5*i +: 5];
         if (hz.d_src_used[i] && s != 0 && ready[s] - t_act > 1) haz = 1'b1;
      end
      if (hz.d_reg_write && hz.d_dst_reg != 0 && ready[hz.d_dst_reg] - t_act > int'(lat))
         haz = 1'b1;
      haz = haz && hz.d_valid;
      ds  = xs || (haz && !fl);
      iss = hz.d_valid && !ds && !fl;
      bub = (ds && !xs) || fl;
      for (int r = 0; r < NR; r++) busy_e[r] = (ready[r] > t_act);

      obs_dstall = hz.d_stall;
      chk("stall_fdx", {hz.f_stall, hz.d_stall, hz.x_stall}, {ds, ds, xs});
      chk("flush_fd",  {hz.f_flush, hz.d_flush}, {fl, fl});
      chk("bubble",    hz.x_bubble, bub);
      chk("busy_vec",  hz.busy_vec, busy_e);
      chk("fwd_sel",   hz.x_fwd_sel, exp_fwd);
      chk("stall_cnt", hz.stall_count, exp_scnt);
      chk("flush_cnt", hz.flush_count, exp_fcnt);

      if (reset) begin
         for (int r = 0; r < NR; r++) ready[r] = 0;
         exp_fwd  = '0;
         exp_scnt = '0;
         exp_fcnt = '0;
      end else begin
`ifdef HAZARD_PERF_EN
         if (ds) exp_scnt = exp_scnt + 32'd1;
         if (fl) exp_fcnt = exp_fcnt + 32'd1;
`endif
         if (!xs) begin
            if (iss) begin
               for (int i = 0; i < NS; i++) begin
                  s = hz.d_src_reg[5*i +: 5];
                  if (s != 0 && hz.x_reg_write && s == hz.x_dst_reg)      f = 2'b01;
                  else if (s != 0 && hz.m_reg_write && s == hz.m_dst_reg) f = 2'b10;
                  else                                                    f = 2'b00;
                  exp_fwd[2*i +: 2] = f;
               end
               if (hz.d_reg_write && hz.d_dst_reg != 0)
                  ready[hz.d_dst_reg] = t_act + 1 + int'(lat);
            end else begin
               exp_fwd = '0;
            end
            t_act++;
         end
      end
      @(negedge clock);
   endtask

   // Write r with lat_a, then either read r (rd=1) or rewrite r with lat_b;
   // count decode stalls before the second instruction issues.
   task automatic seq(input string tag, input logic [4:0] r, input logic [2:0] lat_a,
                      input logic rd, input logic [2:0] lat_b, input int exp_n);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      set_idle();
      hz.d_valid = 1'b1; hz.d_dst_reg = r; hz.d_reg_write = 1'b1; hz.d_latency = lat_a;
      cycle();
      hz.d_reg_write = !rd;
      hz.d_latency   = lat_b;
      hz.d_src_reg   = {5'd0, r};
      hz.d_src_used  = rd ? 2'b01 : 2'b00;
      hz.x_dst_reg   = r;
      hz.x_reg_write = 1'b1;
      for (int k = 0; k < 12 && !done; k++) begin
         cycle();
         if (obs_dstall) n++;
         else done = 1'b1;
      end
      chk({tag, "_stalls"}, n, exp_n);
      if (rd) chk({tag, "_fwd"}, hz.x_fwd_sel[1:0], (r == 0) ? FWD_RF : FWD_XM);
      set_idle();
      repeat (8) cycle();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      t_act    = 0;
      exp_fwd  = '0;
      exp_scnt = '0;
      exp_fcnt = '0;
      for (int r = 0; r < NR; r++) ready[r] = 0;
      set_idle();
      reset = 1'b1;
      @(negedge clock);
      cycle();
      chk("reset_busy", hz.busy_vec, '0);

      seq("alu_raw",  5'd5, 3'd1, 1'b1, 3'd1, 0);
      seq("load_raw", 5'd7, 3'd2, 1'b1, 3'd1, 1);
      seq("waw",      5'd3, 3'd5, 1'b0, 3'd1, 4);
      seq("r0",       5'd0, 3'd7, 1'b1, 3'd1, 0);
      seq("lat0_raw", 5'd9, 3'd0, 1'b1, 3'd1, 0);

      // Reset in the middle of a countdown.
      set_idle();
      hz.d_valid = 1'b1; hz.d_dst_reg = 5'd4; hz.d_reg_write = 1'b1; hz.d_latency = 3'd7;
      cycle();
      set_idle();
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("mid_reset_busy", hz.busy_vec, '0);

      for (int c = 0; c < 1500; c++) begin
         reset          = ($urandom_range(0, 99) < 2);
         hz.d_valid     = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NS; i++) hz.d_src_reg[5*i +: 5] = 5'($urandom_range(0, 7));
         hz.d_src_used  = 2'($urandom_range(0, 3));
         hz.d_dst_reg   = 5'($urandom_range(0, 7));
         hz.d_reg_write = ($urandom_range(0, 3) != 0);
         hz.d_latency   = 3'($urandom_range(0, 7));
         hz.x_dst_reg   = 5'($urandom_range(0, 7));
         hz.m_dst_reg   = 5'($urandom_range(0, 7));
         hz.x_reg_write = 1'($urandom_range(0, 1));
         hz.m_reg_write = 1'($urandom_range(0, 1));
         hz.x_valid     = 1'($urandom_range(0, 1));
         hz.x_alu_ready = ($urandom_range(0, 4) != 0);
         hz.pc_src      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : PC_SEQ;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
